// File: rtl/fir_tap_window.sv
// Serial-to-parallel sample window for a 6-tap FIR datapath: primes six taps,
// optionally decimates, and holds each window stable until the datapath takes it.
module fir_tap_window #(
  parameter int W     = 16,
  parameter int DECIM = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic [W-1:0] s_data,
  input  logic         s_valid,
  output logic         s_ready,
  output logic [W-1:0] tap_1,
  output logic [W-1:0] tap_2,
  output logic [W-1:0] tap_3,
  output logic [W-1:0] tap_4,
  output logic [W-1:0] tap_5,
  output logic [W-1:0] tap_6,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [2:0]   fill_count
);

  typedef enum logic {
    PRIME = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam logic [3:0] DEC_LAST = 4'(DECIM - 1);

  state_t     state, state_next;
  logic [2:0] fill_next;
  logic [3:0] dec_cnt, dec_next;
  logic       m_valid_next;
  logic       accept;
  logic       emit;

  // An unconsumed window blocks intake, so the taps never move under the datapath.
  assign s_ready = !rst && !clear && (!m_valid || m_ready);
  assign accept  = s_valid && s_ready;

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    fill_next  = fill_count;
    dec_next   = dec_cnt;
    emit       = 1'b0;
    case (state)
      PRIME: begin
        if (accept) begin
          fill_next = fill_count + 3'd1;
          if (fill_count == 3'd5) begin
            emit       = 1'b1;
            state_next = RUN;
          end
        end
      end
      RUN: begin
        if (accept) begin
          if (dec_cnt == DEC_LAST) begin
            emit     = 1'b1;
            dec_next = 4'd0;
          end else begin
            dec_next = dec_cnt + 4'd1;
          end
        end
      end
      default: state_next = PRIME;
    endcase

    // A fresh window replaces a consumed one in the same cycle, with no bubble.
    m_valid_next = m_valid;
    if (emit) begin
      m_valid_next = 1'b1;
    end else if (m_valid && m_ready) begin
      m_valid_next = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all taps shift together.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state      <= PRIME;
      fill_count <= 3'd0;
      dec_cnt    <= 4'd0;
      m_valid    <= 1'b0;
      tap_1      <= '0;
      tap_2      <= '0;
      tap_3      <= '0;
      tap_4      <= '0;
      tap_5      <= '0;
      tap_6      <= '0;
    end else begin
      state      <= state_next;
      fill_count <= fill_next;
      dec_cnt    <= dec_next;
      m_valid    <= m_valid_next;
      if (accept) begin
        tap_6 <= tap_5;
        tap_5 <= tap_4;
        tap_4 <= tap_3;
        tap_3 <= tap_2;
        tap_2 <= tap_1;
        tap_1 <= s_data;
      end
    end
  end

endmodule

// File: tb/tb_fir_tap_window.sv
// Self-checking bench: a DECIM=1 and a DECIM=3 instance share stimulus and are
// compared every cycle against a sample-history reference model.
module tb_fir_tap_window;

  logic        clk;
  logic        rst;
  logic        clear;
  logic [15:0] s_data;
  logic        s_valid;
  logic        m_ready;

  logic        srd [2];
  logic        mvd [2];
  logic [2:0]  fcd [2];
  logic [15:0] ta  [6];
  logic [15:0] tb  [6];
  logic [95:0] win [2];

  int checks = 0;
  int errors = 0;

  // Reference model state: accepted-sample history since last restart.
  logic [15:0] hist [2][$];
  int          n_acc [2];
  logic        mv    [2];
  int          decim [2];

  assign win[0] = {ta[0], ta[1], ta[2], ta[3], ta[4], ta[5]};
  assign win[1] = {tb[0], tb[1], tb[2], tb[3], tb[4], tb[5]};

  fir_tap_window #(.W(16), .DECIM(1)) u_d1 (
    .clk(clk), .rst(rst), .clear(clear), .s_data(s_data), .s_valid(s_valid),
    .s_ready(srd[0]), .tap_1(ta[0]), .tap_2(ta[1]), .tap_3(ta[2]), .tap_4(ta[3]),
    .tap_5(ta[4]), .tap_6(ta[5]), .m_valid(mvd[0]), .m_ready(m_ready),
    .fill_count(fcd[0])
  );

  fir_tap_window #(.W(16), .DECIM(3)) u_d3 (
    .clk(clk), .rst(rst), .clear(clear), .s_data(s_data), .s_valid(s_valid),
    .s_ready(srd[1]), .tap_1(tb[0]), .tap_2(tb[1]), .tap_3(tb[2]), .tap_4(tb[3]),
    .tap_5(tb[4]), .tap_6(tb[5]), .m_valid(mvd[1]), .m_ready(m_ready),
    .fill_count(fcd[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected taps are simply the last six accepted samples, newest first.
  function automatic logic [95:0] exp_win(int i);
    logic [95:0] w;
    int          sz;
    w  = '0;
    sz = hist[i].size();
    for (int k = 0; k < 6; k++) begin
      if (k < sz) w[95-16*k -: 16] = hist[i][sz-1-k];
    end
    return w;
  endfunction

  function automatic logic [2:0] exp_fill(int i);
    return (n_acc[i] >= 6) ? 3'd6 : 3'(n_acc[i]);
  endfunction

  // One clock of stimulus; the model is advanced and scored against both DUTs.
  task automatic step(input logic r, input logic c, input logic v,
                      input logic mr, input logic [15:0] d);
    logic exp_sr [2];
    logic emit;
    @(negedge clk);
    rst = r; clear = c; s_valid = v; m_ready = mr; s_data = d;
    #1;
    for (int i = 0; i < 2; i++) begin
      exp_sr[i] = !r && !c && (!mv[i] || mr);
      checks++;
      if (srd[i] !== exp_sr[i]) begin
        errors++;
        $display("FAIL s_ready[%0d] t=%0t: got %b expected %b", i, $time, srd[i], exp_sr[i]);
      end
      if (r || c) begin
        hist[i].delete();
        n_acc[i] = 0;
        mv[i]    = 1'b0;
      end else if (v && exp_sr[i]) begin
        hist[i].push_back(d);
        if (hist[i].size() > 6) void'(hist[i].pop_front());
        n_acc[i]++;
        emit = (n_acc[i] >= 6) && (((n_acc[i] - 6) % decim[i]) == 0);
        if (emit) mv[i] = 1'b1;
        else if (mv[i] && mr) mv[i] = 1'b0;
      end else if (mv[i] && mr) begin
        mv[i] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (win[i] !== exp_win(i)) begin
        errors++;
        $display("FAIL taps[%0d] t=%0t: got %h expected %h", i, $time, win[i], exp_win(i));
      end
      checks++;
      if (mvd[i] !== mv[i]) begin
        errors++;
        $display("FAIL m_valid[%0d] t=%0t: got %b expected %b", i, $time, mvd[i], mv[i]);
      end
      checks++;
      if (fcd[i] !== exp_fill(i)) begin
        errors++;
        $display("FAIL fill_count[%0d] t=%0t: got %0d expected %0d", i, $time, fcd[i], exp_fill(i));
      end
    end
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 1'b1, 1'b1, 16'h00AA);
    step(1'b1, 1'b0, 1'b1, 1'b1, 16'h00BB);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (win[i] !== 96'd0 || mvd[i] !== 1'b0 || fcd[i] !== 3'd0) begin
        errors++;
        $display("FAIL reset_state[%0d]: got taps %h m_valid %b fill %0d expected all zero",
                 i, win[i], mvd[i], fcd[i]);
      end
    end
  endtask

  task automatic test_priming();
    for (int k = 1; k <= 6; k++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1, 16'(k));
      if (k == 5) begin
        checks++;
        if (mvd[0] !== 1'b0 || mvd[1] !== 1'b0) begin
          errors++;
          $display("FAIL prime_no_early_valid: got %b %b expected 0 0", mvd[0], mvd[1]);
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (win[i] !== {16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1} || mvd[i] !== 1'b1) begin
        errors++;
        $display("FAIL first_window[%0d]: got %h valid %b expected 6..1 valid 1", i, win[i], mvd[i]);
      end
    end
    step(1'b0, 1'b0, 1'b1, 1'b1, 16'd7);
    checks++;
    if (win[0] !== {16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2} || mvd[0] !== 1'b1) begin
      errors++;
      $display("FAIL run_d1_window: got %h valid %b expected 7..2 valid 1", win[0], mvd[0]);
    end
  endtask

  task automatic test_decimation();
    checks++;
    if (mvd[1] !== 1'b0) begin
      errors++;
      $display("FAIL decim_skip7: got m_valid %b expected 0", mvd[1]);
    end
    step(1'b0, 1'b0, 1'b1, 1'b1, 16'd8);
    checks++;
    if (mvd[1] !== 1'b0) begin
      errors++;
      $display("FAIL decim_skip8: got m_valid %b expected 0", mvd[1]);
    end
    step(1'b0, 1'b0, 1'b1, 1'b1, 16'd9);
    checks++;
    if (win[1] !== {16'd9, 16'd8, 16'd7, 16'd6, 16'd5, 16'd4} || mvd[1] !== 1'b1) begin
      errors++;
      $display("FAIL decim_window: got %h valid %b expected 9..4 valid 1", win[1], mvd[1]);
    end
  endtask

  task automatic test_backpressure();
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, 16'd10);
      checks++;
      if (srd[0] !== 1'b0 || win[0] !== {16'd9, 16'd8, 16'd7, 16'd6, 16'd5, 16'd4}) begin
        errors++;
        $display("FAIL stall_freeze: got s_ready %b taps %h expected 0 and 9..4", srd[0], win[0]);
      end
    end
    step(1'b0, 1'b0, 1'b1, 1'b1, 16'd10);
    checks++;
    if (win[0] !== {16'd10, 16'd9, 16'd8, 16'd7, 16'd6, 16'd5} || mvd[0] !== 1'b1) begin
      errors++;
      $display("FAIL stall_release: got %h valid %b expected 10..5 valid 1", win[0], mvd[0]);
    end
    step(1'b0, 1'b0, 1'b1, 1'b1, 16'd11);
    checks++;
    if (win[0] !== {16'd11, 16'd10, 16'd9, 16'd8, 16'd7, 16'd6}) begin
      errors++;
      $display("FAIL stall_no_dup: got %h expected 11..6", win[0]);
    end
  endtask

  task automatic test_clear();
    step(1'b0, 1'b1, 1'b0, 1'b1, 16'd0);
    for (int k = 1; k <= 4; k++) step(1'b0, 1'b0, 1'b1, 1'b1, 16'(k));
    step(1'b0, 1'b1, 1'b1, 1'b1, 16'd5);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (fcd[i] !== 3'd0 || win[i] !== 96'd0 || mvd[i] !== 1'b0) begin
        errors++;
        $display("FAIL clear_midstream[%0d]: got fill %0d taps %h expected 0 and zero taps",
                 i, fcd[i], win[i]);
      end
    end
    for (int k = 10; k <= 15; k++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1, 16'(k));
      if (k == 14) begin
        checks++;
        if (mvd[0] !== 1'b0) begin
          errors++;
          $display("FAIL clear_reprime: got m_valid %b expected 0", mvd[0]);
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (win[i] !== {16'd15, 16'd14, 16'd13, 16'd12, 16'd11, 16'd10} || mvd[i] !== 1'b1) begin
        errors++;
        $display("FAIL clear_first_window[%0d]: got %h valid %b expected 15..10", i, win[i], mvd[i]);
      end
    end
  endtask

  task automatic test_width();
    step(1'b0, 1'b0, 1'b1, 1'b1, 16'hFFFF);
    step(1'b0, 1'b0, 1'b1, 1'b1, 16'h8000);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (win[i] !== {16'h8000, 16'hFFFF, 16'd15, 16'd14, 16'd13, 16'd12}) begin
        errors++;
        $display("FAIL width_corner[%0d]: got %h expected 8000 ffff 15..12", i, win[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      step(1'b0, ($urandom % 60) == 0, ($urandom % 4) != 0, ($urandom % 3) != 0,
           16'($urandom));
    end
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_data = '0;
    decim[0] = 1;
    decim[1] = 3;
    for (int i = 0; i < 2; i++) begin
      n_acc[i] = 0;
      mv[i]    = 1'b0;
    end
    test_reset();
    test_priming();
    test_decimation();
    test_backpressure();
    test_clear();
    test_width();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
